// File: rtl/fpa_arbiter.sv
// fpa_arbiter: round-robin sharing of one combinational fpa among NUM_REQ requesters; ports: clk/rst, req_valid/req_ready/req_a/req_b/req_op per requester, registered fpa_a/fpa_b/fpa_op out with fpa_result back, tagged rsp_valid/rsp_ready/rsp_id/rsp_data response, busy and ops_done status
module fpa_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W = 2,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*32-1:0] req_a,
  input  logic [NUM_REQ*32-1:0] req_b,
  input  logic [NUM_REQ-1:0]    req_op,
  output logic [31:0]           fpa_a,
  output logic [31:0]           fpa_b,
  output logic                  fpa_op,
  input  logic [31:0]           fpa_result,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [31:0]           rsp_data,
  output logic                  busy,
  output logic [CNT_W-1:0]      ops_done
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state, state_n;
  logic [ID_W-1:0] ptr, off, win, win_n;
  logic [ID_W:0] sum;
  logic [NUM_REQ-1:0] rot;
  logic any, take;
  assign rot = NUM_REQ'({req_valid, req_valid} >> ptr);
  always_comb begin
    off = '0;
    any = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (rot[k]) begin
        off = ID_W'(k);
        any = 1'b1;
      end
  end
  assign sum = {1'b0, ptr} + {1'b0, off};
  assign win = sum >= (ID_W+1)'(NUM_REQ) ? ID_W'(sum - (ID_W+1)'(NUM_REQ)) : ID_W'(sum);
  assign win_n = win == ID_W'(NUM_REQ - 1) ? '0 : win + 1'b1;
  assign take = state == IDLE && any;
  assign req_ready = take ? NUM_REQ'(1) << win : '0;
  assign rsp_valid = state == RESP;
  assign busy = state != IDLE;
  always_comb begin
    state_n = state;
    state_n = take ? EXEC : state == EXEC ? RESP : (state == RESP && rsp_ready) ? IDLE : state;
  end
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
      fpa_a <= '0;
      fpa_b <= '0;
      fpa_op <= 1'b0;
      rsp_id <= '0;
      rsp_data <= '0;
      ops_done <= '0;
    end else begin
      if (take) begin
        fpa_a <= req_a[32*win +: 32];
        fpa_b <= req_b[32*win +: 32];
        fpa_op <= req_op[win];
        rsp_id <= win;
        ptr <= win_n;
      end
      if (state == EXEC) rsp_data <= fpa_result;
      if (rsp_valid && rsp_ready) ops_done <= ops_done + 1'b1;
    end
  end
endmodule
